// File: rtl/srr_pkg.sv
// srr_pkg: shared types and constants for the secure register reader.
//   auth_state_e : unlock FSM states
//   RD_LATENCY   : accept-to-result latency in cycles
//   DEFAULT_KEY  : default unlock key
package srr_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } auth_state_e;

    localparam int unsigned RD_LATENCY  = 2;
    localparam logic [31:0] DEFAULT_KEY = 32'hA5C3_5A3C;

endpackage

// File: rtl/srr_unlock_ctrl.sv
// srr_unlock_ctrl: key-based unlock FSM with timed access window and
// consecutive-bad-key counting. Optional lockout under SECURE_READ_LOCKOUT_EN.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   unlock_valid/key    : candidate key strobe and value
//   lock_req            : force relock (wins over a same-cycle key)
//   unlocked            : access window open
//   locked_out          : lockout active (tied 0 without the macro)
//   grant_ok_c          : window still open after the current edge
module srr_unlock_ctrl
    import srr_pkg::*;
#(
    parameter int unsigned        DATA_W        = 32,
    parameter logic [DATA_W-1:0]  UNLOCK_KEY    = DATA_W'(DEFAULT_KEY),
    parameter int unsigned        UNLOCK_WINDOW = 64,
    parameter int unsigned        MAX_FAIL      = 3,
    parameter int unsigned        LOCK_CYCLES   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              unlock_valid,
    input  logic [DATA_W-1:0] unlock_key,
    input  logic              lock_req,
    output logic              unlocked,
    output logic              locked_out,
    output logic              grant_ok_c
);

    localparam int unsigned WIN_W  = $clog2(UNLOCK_WINDOW + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

    auth_state_e       state_q, state_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [FAIL_W-1:0] fail_inc;
    logic              key_ok, key_bad;

`ifdef SECURE_READ_LOCKOUT_EN
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
    logic [LOCK_W-1:0] lock_q, lock_d;
`endif

    // Next-state logic for the auth FSM and its counters.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        fail_d   = fail_q;
`ifdef SECURE_READ_LOCKOUT_EN
        lock_d   = lock_q;
`endif
        key_ok   = unlock_valid && (unlock_key == UNLOCK_KEY);
        key_bad  = unlock_valid && (unlock_key != UNLOCK_KEY);
        fail_inc = (fail_q == FAIL_W'(MAX_FAIL)) ? fail_q : fail_q + FAIL_W'(1);

        case (state_q)
            LOCKED: begin
                if (lock_req) begin
                    state_d = LOCKED;
                end else if (key_ok) begin
                    state_d = UNLOCKED;
                    win_d   = WIN_W'(UNLOCK_WINDOW);
                    fail_d  = '0;
                end else if (key_bad) begin
                    fail_d  = fail_inc;
                end
            end
            UNLOCKED: begin
                if (lock_req) begin
                    state_d = LOCKED;
                    win_d   = '0;
                end else if (key_ok) begin
                    win_d   = WIN_W'(UNLOCK_WINDOW);
                end else if (key_bad) begin
                    state_d = LOCKED;
                    win_d   = '0;
                    fail_d  = fail_inc;
                end else if (win_q <= WIN_W'(1)) begin
                    // Last cycle of the window: close on this edge.
                    state_d = LOCKED;
                    win_d   = '0;
                end else begin
                    win_d   = win_q - WIN_W'(1);
                end
            end
`ifdef SECURE_READ_LOCKOUT_EN
            LOCKOUT: begin
                if (lock_q <= LOCK_W'(1)) begin
                    state_d = LOCKED;
                    lock_d  = '0;
                    fail_d  = '0;
                end else begin
                    lock_d  = lock_q - LOCK_W'(1);
                end
            end
`endif
            default: begin
                state_d = LOCKED;
                win_d   = '0;
            end
        endcase

`ifdef SECURE_READ_LOCKOUT_EN
        // Reaching the failure limit overrides whatever else happened this edge.
        if ((state_q != LOCKOUT) && (fail_d == FAIL_W'(MAX_FAIL))) begin
            state_d = LOCKOUT;
            win_d   = '0;
            lock_d  = LOCK_W'(LOCK_CYCLES);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOCKED;
            win_q   <= '0;
            fail_q  <= '0;
`ifdef SECURE_READ_LOCKOUT_EN
            lock_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fail_q  <= fail_d;
`ifdef SECURE_READ_LOCKOUT_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign unlocked   = (state_q == UNLOCKED);
`ifdef SECURE_READ_LOCKOUT_EN
    assign locked_out = (state_q == LOCKOUT);
`else
    assign locked_out = 1'b0;
`endif
    // A read sampled on the window's final edge is denied.
    assign grant_ok_c = unlocked && (win_q > WIN_W'(1));

endmodule

// File: rtl/secure_reg_reader.sv
// secure_reg_reader: read-side access controller for the sensitive register
// bank. Granted and denied reads both return two cycles after accept; denied
// reads never strobe the bank and return zero data with rd_err.
// Optional lockout after repeated bad keys: define SECURE_READ_LOCKOUT_EN.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   unlock_valid/unlock_key      : unlock key presentation
//   lock_req                     : force relock
//   rd_req/rd_addr/rd_priv       : read request, accepted when rd_ready
//   rd_ready                     : read can be accepted
//   reg_rd_en/reg_rd_addr        : bank read strobe and address
//   reg_rd_data                  : bank data, one cycle after reg_rd_en
//   rd_valid/rd_data/rd_err      : result strobe, data, denial flag
//   unlocked, locked_out         : auth status
module secure_reg_reader
    import srr_pkg::*;
#(
    parameter int unsigned        DATA_W        = 32,
    parameter int unsigned        ADDR_W        = 3,
    parameter logic [DATA_W-1:0]  UNLOCK_KEY    = DATA_W'(DEFAULT_KEY),
    parameter int unsigned        UNLOCK_WINDOW = 64,
    parameter int unsigned        MAX_FAIL      = 3,
    parameter int unsigned        LOCK_CYCLES   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              unlock_valid,
    input  logic [DATA_W-1:0] unlock_key,
    input  logic              lock_req,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_priv,
    output logic              rd_ready,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_rd_addr,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              unlocked,
    output logic              locked_out
);

    logic              grant_ok_c;
    logic              accept_c, grant_c;
    logic              rd_ready_q, rd_ready_d;
    logic              reg_rd_en_q, reg_rd_en_d;
    logic [ADDR_W-1:0] reg_rd_addr_q, reg_rd_addr_d;
    logic              s1_valid_q, s1_valid_d, s1_grant_q, s1_grant_d;
    logic              s2_valid_q, s2_valid_d, s2_grant_q, s2_grant_d;
    logic              rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    srr_unlock_ctrl #(
        .DATA_W        (DATA_W),
        .UNLOCK_KEY    (UNLOCK_KEY),
        .UNLOCK_WINDOW (UNLOCK_WINDOW),
        .MAX_FAIL      (MAX_FAIL),
        .LOCK_CYCLES   (LOCK_CYCLES)
    ) u_unlock_ctrl (
        .clk          (clk),
        .rst          (rst),
        .unlock_valid (unlock_valid),
        .unlock_key   (unlock_key),
        .lock_req     (lock_req),
        .unlocked     (unlocked),
        .locked_out   (locked_out),
        .grant_ok_c   (grant_ok_c)
    );

    assign accept_c = rd_req && rd_ready_q;
    assign grant_c  = accept_c && rd_priv && grant_ok_c;

    // Two-stage read pipeline; the grant decision travels with the read.
    always_comb begin
        rd_ready_d    = !accept_c;
        reg_rd_en_d   = grant_c;
        reg_rd_addr_d = grant_c ? rd_addr : reg_rd_addr_q;
        s1_valid_d    = accept_c;
        s1_grant_d    = grant_c;
        s2_valid_d    = s1_valid_q;
        s2_grant_d    = s1_grant_q;
        rd_valid_d    = s2_valid_q;
        rd_err_d      = s2_valid_q && !s2_grant_q;
        rd_data_d     = (s2_valid_q && s2_grant_q) ? reg_rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ready_q    <= 1'b1;
            reg_rd_en_q   <= 1'b0;
            reg_rd_addr_q <= '0;
            s1_valid_q    <= 1'b0;
            s1_grant_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_grant_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_err_q      <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            rd_ready_q    <= rd_ready_d;
            reg_rd_en_q   <= reg_rd_en_d;
            reg_rd_addr_q <= reg_rd_addr_d;
            s1_valid_q    <= s1_valid_d;
            s1_grant_q    <= s1_grant_d;
            s2_valid_q    <= s2_valid_d;
            s2_grant_q    <= s2_grant_d;
            rd_valid_q    <= rd_valid_d;
            rd_err_q      <= rd_err_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign rd_ready    = rd_ready_q;
    assign reg_rd_en   = reg_rd_en_q;
    assign reg_rd_addr = reg_rd_addr_q;
    assign rd_valid    = rd_valid_q;
    assign rd_err      = rd_err_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_secure_reg_reader.sv
// tb_secure_reg_reader: directed bench for secure_reg_reader with a simple
// synchronous register bank model.
module tb_secure_reg_reader;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned WIN    = 64;
    localparam logic [31:0] KEY    = 32'hA5C3_5A3C;
    localparam logic [31:0] BAD    = 32'h1234_5678;

    logic              clk = 1'b0;
    logic              rst;
    logic              unlock_valid;
    logic [DATA_W-1:0] unlock_key;
    logic              lock_req;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_priv;
    logic              rd_ready;
    logic              reg_rd_en;
    logic [ADDR_W-1:0] reg_rd_addr;
    logic [DATA_W-1:0] reg_rd_data = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic              unlocked;
    logic              locked_out;

    logic [DATA_W-1:0] bank [8];
    logic [ADDR_W-1:0] last_addr;
    int                n_vec = 0;
    int                n_err = 0;

    secure_reg_reader dut (
        .clk          (clk),
        .rst          (rst),
        .unlock_valid (unlock_valid),
        .unlock_key   (unlock_key),
        .lock_req     (lock_req),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_priv      (rd_priv),
        .rd_ready     (rd_ready),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_addr  (reg_rd_addr),
        .reg_rd_data  (reg_rd_data),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_err       (rd_err),
        .unlocked     (unlocked),
        .locked_out   (locked_out)
    );

    always #5 clk = ~clk;

    // Synchronous bank: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= bank[reg_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic v, input logic [31:0] k, input logic lr);
        unlock_valid = v;
        unlock_key   = k;
        lock_req     = lr;
        step();
        unlock_valid = 1'b0;
        lock_req     = 1'b0;
    endtask

    // One read accepted at the next edge (E0); result checked at E2.
    task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic p,
                           input logic g, input logic [31:0] d);
        rd_req  = 1'b1;
        rd_addr = a;
        rd_priv = p;
        step();
        rd_req  = 1'b0;
        rd_priv = 1'b0;
        if (g) last_addr = a;
        chk({tag, "/en"},    32'(reg_rd_en), 32'(g));
        chk({tag, "/addr"},  32'(reg_rd_addr), 32'(last_addr));
        chk({tag, "/rdy0"},  32'(rd_ready), 32'd0);
        step();
        chk({tag, "/rdy1"},  32'(rd_ready), 32'd1);
        chk({tag, "/enlo"},  32'(reg_rd_en), 32'd0);
        chk({tag, "/vlo"},   32'(rd_valid), 32'd0);
        step();
        chk({tag, "/valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "/data"},  rd_data, g ? d : 32'd0);
        chk({tag, "/err"},   32'(rd_err), 32'(!g));
        step();
        chk({tag, "/vend"},  32'(rd_valid), 32'd0);
        chk({tag, "/dend"},  rd_data, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) bank[i] = 32'h1000_0000 + 32'(i);
        bank[3]      = 32'hDEAD_BEEF;
        last_addr    = '0;
        rst          = 1'b1;
        unlock_valid = 1'b0;
        unlock_key   = '0;
        lock_req     = 1'b0;
        rd_req       = 1'b0;
        rd_addr      = '0;
        rd_priv      = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst/rdy",  32'(rd_ready), 32'd1);
        chk("rst/en",   32'(reg_rd_en), 32'd0);
        chk("rst/addr", 32'(reg_rd_addr), 32'd0);
        chk("rst/vld",  32'(rd_valid), 32'd0);
        chk("rst/data", rd_data, 32'd0);
        chk("rst/err",  32'(rd_err), 32'd0);
        chk("rst/unl",  32'(unlocked), 32'd0);
        chk("rst/lko",  32'(locked_out), 32'd0);
        rst = 1'b0;
        step();

        // Locked read is denied
        do_read("locked", 3'd3, 1'b1, 1'b0, 32'd0);

        // Unlock then granted reads
        key(1'b1, KEY, 1'b0);
        chk("unl/up", 32'(unlocked), 32'd1);
        do_read("grant3", 3'd3, 1'b1, 1'b1, 32'hDEAD_BEEF);
        do_read("nopriv", 3'd5, 1'b0, 1'b0, 32'd0);
        do_read("grant5", 3'd5, 1'b1, 1'b1, 32'h1000_0005);

        // Back-to-back: second request held through rd_ready=0, accepted at E2
        rd_req = 1'b1; rd_addr = 3'd2; rd_priv = 1'b1;
        step();
        rd_addr = 3'd6;
        step();
        chk("b2b/en_e1", 32'(reg_rd_en), 32'd0);
        chk("b2b/rdy",   32'(rd_ready), 32'd1);
        step();
        rd_req = 1'b0; rd_priv = 1'b0;
        chk("b2b/v1",    32'(rd_valid), 32'd1);
        chk("b2b/d1",    rd_data, 32'h1000_0002);
        chk("b2b/en2",   32'(reg_rd_en), 32'd1);
        chk("b2b/a2",    32'(reg_rd_addr), 32'd6);
        last_addr = 3'd6;
        step();
        chk("b2b/vgap",  32'(rd_valid), 32'd0);
        step();
        chk("b2b/v2",    32'(rd_valid), 32'd1);
        chk("b2b/d2",    rd_data, 32'h1000_0006);
        step();

        // lock_req wins over a correct key, from UNLOCKED and from LOCKED
        key(1'b1, KEY, 1'b1);
        chk("lock/unl", 32'(unlocked), 32'd0);
        key(1'b1, KEY, 1'b1);
        chk("lock/stay", 32'(unlocked), 32'd0);
        do_read("lockrd", 3'd1, 1'b1, 1'b0, 32'd0);

        // Bad key while unlocked relocks
        key(1'b1, KEY, 1'b0);
        chk("bad/pre", 32'(unlocked), 32'd1);
        key(1'b1, BAD, 1'b0);
        chk("bad/unl", 32'(unlocked), 32'd0);
        key(1'b1, KEY, 1'b0);
        chk("bad/re", 32'(unlocked), 32'd1);
        key(1'b0, 32'd0, 1'b1);
        chk("bad/lk", 32'(unlocked), 32'd0);

        // Window length: high for exactly WIN cycles
        key(1'b1, KEY, 1'b0);
        repeat (WIN - 1) step();
        chk("win/last", 32'(unlocked), 32'd1);
        step();
        chk("win/fell", 32'(unlocked), 32'd0);
        do_read("winpost", 3'd1, 1'b1, 1'b0, 32'd0);

        // Read accepted one edge before expiry is granted
        key(1'b1, KEY, 1'b0);
        repeat (WIN - 2) step();
        do_read("winedge-1", 3'd1, 1'b1, 1'b1, 32'h1000_0001);
        chk("winedge-1/unl", 32'(unlocked), 32'd0);

        // Read accepted at K+WIN is denied
        key(1'b1, KEY, 1'b0);
        repeat (WIN - 1) step();
        do_read("winedge", 3'd4, 1'b1, 1'b0, 32'd0);

        // Correct key while unlocked reloads the window
        key(1'b1, KEY, 1'b0);
        repeat (30) step();
        key(1'b1, KEY, 1'b0);
        repeat (WIN - 1) step();
        chk("reload/last", 32'(unlocked), 32'd1);
        step();
        chk("reload/fell", 32'(unlocked), 32'd0);

        // Consecutive bad keys
        key(1'b1, BAD, 1'b0);
        chk("fail1/lko", 32'(locked_out), 32'd0);
        key(1'b1, BAD, 1'b0);
        chk("fail2/lko", 32'(locked_out), 32'd0);
        key(1'b1, BAD, 1'b0);
`ifdef SECURE_READ_LOCKOUT_EN
        chk("fail3/lko", 32'(locked_out), 32'd1);
        key(1'b1, KEY, 1'b0);
        chk("lko/keyign", 32'(unlocked), 32'd0);
        chk("lko/still", 32'(locked_out), 32'd1);
        repeat (14) step();
        chk("lko/last", 32'(locked_out), 32'd1);
        step();
        chk("lko/exit", 32'(locked_out), 32'd0);
        chk("lko/exitunl", 32'(unlocked), 32'd0);
`else
        chk("fail3/lko", 32'(locked_out), 32'd0);
        key(1'b1, BAD, 1'b0);
        chk("fail4/lko", 32'(locked_out), 32'd0);
        chk("fail4/unl", 32'(unlocked), 32'd0);
`endif
        key(1'b1, KEY, 1'b0);
        chk("postfail/unl", 32'(unlocked), 32'd1);

        // Reset at E1 of a granted read discards it
        rd_req = 1'b1; rd_addr = 3'd4; rd_priv = 1'b1;
        step();
        rd_req = 1'b0; rd_priv = 1'b0;
        chk("mrst/en", 32'(reg_rd_en), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst/rdy",  32'(rd_ready), 32'd1);
        chk("mrst/en0",  32'(reg_rd_en), 32'd0);
        chk("mrst/addr", 32'(reg_rd_addr), 32'd0);
        chk("mrst/unl",  32'(unlocked), 32'd0);
        chk("mrst/lko",  32'(locked_out), 32'd0);
        chk("mrst/vld",  32'(rd_valid), 32'd0);
        chk("mrst/err",  32'(rd_err), 32'd0);
        chk("mrst/data", rd_data, 32'd0);
        step();
        chk("mrst/e2", 32'(rd_valid), 32'd0);
        step();
        chk("mrst/e3", 32'(rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
